// File: rtl/arena_render_if.sv
// Pixel-stage bus for arena_render: VGA timing in, map write port, DAC outputs.
// Signal names follow the existing VGA timing generator and DAC wiring.
interface arena_render_if;
  logic       HS, VS, blank, SOF, SOL, EOL;
  logic       wr_en;
  logic [4:0] wr_col;
  logic [3:0] wr_row;
  logic [1:0] wr_type;
  logic       wr_ready, init_done;
  logic [7:0] R, G, B;
  logic       VGA_HS, VGA_VS, VGA_BLANK;

  modport master (
    output HS, VS, blank, SOF, SOL, EOL, wr_en, wr_col, wr_row, wr_type,
    input  wr_ready, init_done, R, G, B, VGA_HS, VGA_VS, VGA_BLANK
  );
  modport slave (
    input  HS, VS, blank, SOF, SOL, EOL, wr_en, wr_col, wr_row, wr_type,
    output wr_ready, init_done, R, G, B, VGA_HS, VGA_VS, VGA_BLANK
  );
endinterface

// File: rtl/arena_render.sv
// Arena pixel colour stage: cell tracking, 20x15 tile map, 3-stage colour pipe.
// Optional ARENA_GRID_EN draws a darker grid line on the top/left pixel of empty cells.
module arena_render #(
  parameter int CELL_PX = 40,
  parameter int MAP_W   = 20,
  parameter int MAP_H   = 15,
  parameter int LAT     = 3
) (
  input logic           clock_50,
  input logic           reset_n,
  arena_render_if.slave bus
);
  localparam int          MAP_N     = MAP_W * MAP_H;
  localparam logic [5:0]  PX_LAST   = 6'(CELL_PX - 1);
  localparam logic [4:0]  COL_LAST  = 5'(MAP_W - 1);
  localparam logic [3:0]  ROW_LAST  = 4'(MAP_H - 1);
  localparam logic [8:0]  ADDR_LAST = 9'(MAP_N - 1);
  localparam logic [1:0]  T_EMPTY = 2'd0, T_WALL = 2'd1, T_BRICK = 2'd2, T_BOMB = 2'd3;
  localparam logic [23:0] EMPTY_RGB  = 24'h20A020;
  localparam logic [23:0] WALL_RGB   = 24'h808080;
  localparam logic [23:0] WEDGE_RGB  = 24'h404040;
  localparam logic [23:0] BRICK_RGB  = 24'hB04020;
  localparam logic [23:0] MORTAR_RGB = 24'h602010;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t     r_state;
  logic [8:0] r_iaddr;
  logic [4:0] r_icol;
  logic [3:0] r_irow;
  logic       r_init_done, r_wr_ready;

  // Layout generator walks the map in address order, tracking col/row alongside.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_iaddr     <= '0;
      r_icol      <= '0;
      r_irow      <= '0;
      r_init_done <= 1'b0;
      r_wr_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_iaddr == ADDR_LAST) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
            r_wr_ready  <= 1'b1;
          end else begin
            r_iaddr <= r_iaddr + 9'd1;
            if (r_icol == COL_LAST) begin
              r_icol <= '0;
              r_irow <= r_irow + 4'd1;
            end else begin
              r_icol <= r_icol + 5'd1;
            end
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  logic       w_init_wall, w_wr_ok, w_map_we;
  logic [8:0] w_wr_addr, w_map_waddr;
  logic [1:0] w_map_wdata;
  logic [1:0] r_map [MAP_N];

  assign w_init_wall = (r_irow == 4'd0) || (r_irow == ROW_LAST) ||
                       (r_icol == 5'd0) || (r_icol == COL_LAST) ||
                       (!r_icol[0] && !r_irow[0]);
  assign w_wr_addr   = 9'(bus.wr_row) * 9'(MAP_W) + 9'(bus.wr_col);
  assign w_wr_ok     = (r_state == S_RUN) && (bus.wr_col <= COL_LAST) && (bus.wr_row <= ROW_LAST);
  assign w_map_we    = (r_state == S_INIT) || (bus.wr_en && w_wr_ok);
  assign w_map_waddr = (r_state == S_INIT) ? r_iaddr : w_wr_addr;
  assign w_map_wdata = (r_state == S_INIT) ? (w_init_wall ? T_WALL : T_EMPTY) : bus.wr_type;

  always_ff @(posedge clock_50) begin
    if (w_map_we) r_map[w_map_waddr] <= w_map_wdata;
  end

  // SOL/SOF force the current pixel to the line/frame origin without waiting a cycle.
  logic [5:0] r_px, r_py, w_cur_px, w_cur_py;
  logic [4:0] r_col, w_cur_col;
  logic [3:0] r_row, w_cur_row;

  assign w_cur_px  = bus.SOL ? '0 : r_px;
  assign w_cur_col = bus.SOL ? '0 : r_col;
  assign w_cur_py  = bus.SOF ? '0 : r_py;
  assign w_cur_row = bus.SOF ? '0 : r_row;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_px  <= '0;
      r_col <= '0;
      r_py  <= '0;
      r_row <= '0;
    end else begin
      if (bus.blank) begin
        if (w_cur_px == PX_LAST) begin
          r_px  <= '0;
          r_col <= (w_cur_col == COL_LAST) ? w_cur_col : w_cur_col + 5'd1;
        end else begin
          r_px  <= w_cur_px + 6'd1;
          r_col <= w_cur_col;
        end
      end
      if (bus.SOF) begin
        r_py  <= '0;
        r_row <= '0;
      end else if (bus.EOL) begin
        if (r_py == PX_LAST) begin
          r_py  <= '0;
          r_row <= (r_row == ROW_LAST) ? r_row : r_row + 4'd1;
        end else begin
          r_py <= r_py + 6'd1;
        end
      end
    end
  end

  logic [5:0]              r1_px, r1_py, r2_px, r2_py;
  logic [4:0]              r1_col;
  logic [3:0]              r1_row;
  logic [1:0]              r2_cell;
  logic [LAT-1:0][2:0]     r_sync_pipe;   // {HS, VS, blank} per stage
  logic [23:0]             r_rgb, w_rgb, w_empty_rgb;
  logic [8:0]              w_rd_addr;
  logic                    w_blank_s2;

  assign w_rd_addr  = 9'(r1_row) * 9'(MAP_W) + 9'(r1_col);
  assign w_blank_s2 = r_sync_pipe[LAT-2][0];

`ifdef ARENA_GRID_EN
  localparam logic [23:0] GRID_RGB = 24'h107010;
  assign w_empty_rgb = (r2_px == 6'd0 || r2_py == 6'd0) ? GRID_RGB : EMPTY_RGB;
`else
  assign w_empty_rgb = EMPTY_RGB;
`endif

  always_comb begin
    w_rgb = w_empty_rgb;
    case (r2_cell)
      T_WALL:  w_rgb = (r2_px == 6'd0 || r2_px == PX_LAST || r2_py == 6'd0 || r2_py == PX_LAST)
                       ? WEDGE_RGB : WALL_RGB;
      T_BRICK: w_rgb = (r2_py == 6'd0 || r2_py == 6'd10 || r2_py == 6'd20 || r2_py == 6'd30)
                       ? MORTAR_RGB : BRICK_RGB;
      T_BOMB:  w_rgb = (r2_px >= 6'd8 && r2_px <= 6'd31 && r2_py >= 6'd8 && r2_py <= 6'd31)
                       ? 24'h000000 : w_empty_rgb;
      default: w_rgb = w_empty_rgb;
    endcase
    if (!w_blank_s2 || !r_init_done) w_rgb = '0;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r1_px       <= '0;
      r1_py       <= '0;
      r1_col      <= '0;
      r1_row      <= '0;
      r2_px       <= '0;
      r2_py       <= '0;
      r2_cell     <= '0;
      r_rgb       <= '0;
      r_sync_pipe <= {LAT{3'b110}};
    end else begin
      r1_px       <= w_cur_px;
      r1_py       <= w_cur_py;
      r1_col      <= w_cur_col;
      r1_row      <= w_cur_row;
      r2_px       <= r1_px;
      r2_py       <= r1_py;
      r2_cell     <= r_map[w_rd_addr];
      r_rgb       <= w_rgb;
      r_sync_pipe <= {r_sync_pipe[LAT-2:0], {bus.HS, bus.VS, bus.blank}};
    end
  end

  assign bus.R         = r_rgb[23:16];
  assign bus.G         = r_rgb[15:8];
  assign bus.B         = r_rgb[7:0];
  assign bus.VGA_HS    = r_sync_pipe[LAT-1][2];
  assign bus.VGA_VS    = r_sync_pipe[LAT-1][1];
  assign bus.VGA_BLANK = r_sync_pipe[LAT-1][0];
  assign bus.wr_ready  = r_wr_ready;
  assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_arena_render.sv
// Directed bench for arena_render: init timing, map layout, writes, sync delay, mid-frame reset.
// Uses 240-pixel active lines to keep runtime short; the DUT only follows the strobes.
module tb_arena_render;
  logic clock_50 = 1'b0;
  logic reset_n  = 1'b1;
  arena_render_if bus();

  arena_render dut (.clock_50(clock_50), .reset_n(reset_n), .bus(bus));

  always #10 clock_50 = ~clock_50;

  localparam int LINE_W = 240;
`ifdef ARENA_GRID_EN
  localparam logic [23:0] GRID = 24'h107010;
`else
  localparam logic [23:0] GRID = 24'h20A020;
`endif

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Pixel coordinates delayed alongside the DUT pipeline.
  int cur_x = 0, cur_y = 0;
  bit cur_act = 1'b0;
  int dx [1:3], dy [1:3];
  bit da [1:3];

  always @(posedge clock_50) begin
    dx[1] <= cur_x;  dy[1] <= cur_y;  da[1] <= cur_act;
    dx[2] <= dx[1];  dy[2] <= dy[1];  da[2] <= da[1];
    dx[3] <= dx[2];  dy[3] <= dy[2];  da[3] <= da[2];
  end

  int          cp_x[$], cp_y[$];
  logic [23:0] cp_rgb[$];
  int          cp_hits = 0;

  always @(posedge clock_50) begin
    #1;
    if (da[3])
      for (int i = 0; i < cp_x.size(); i++)
        if (dx[3] == cp_x[i] && dy[3] == cp_y[i]) begin
          chk($sformatf("pix(%0d,%0d)", cp_x[i], cp_y[i]), {bus.R, bus.G, bus.B}, cp_rgb[i]);
          cp_hits++;
        end
  end

  task automatic add_cp(input int x, input int y, input logic [23:0] rgb);
    cp_x.push_back(x); cp_y.push_back(y); cp_rgb.push_back(rgb);
  endtask

  task automatic clear_cp();
    cp_x.delete(); cp_y.delete(); cp_rgb.delete(); cp_hits = 0;
  endtask

  task automatic idle();
    bus.blank = 1'b0; bus.SOL = 1'b0; bus.SOF = 1'b0; bus.EOL = 1'b0;
    bus.HS = 1'b1; bus.VS = 1'b1; cur_act = 1'b0;
  endtask

  // Called aligned to a falling edge; inputs change only on falling edges.
  task automatic line(input int y);
    for (int x = 0; x < LINE_W; x++) begin
      bus.blank = 1'b1; bus.SOL = (x == 0); bus.SOF = (x == 0 && y == 0);
      bus.EOL = (x == LINE_W - 1); bus.HS = 1'b1;
      cur_x = x; cur_y = y; cur_act = 1'b1;
      @(negedge clock_50);
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      bus.HS = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      @(negedge clock_50);
    end
  endtask

  task automatic frame(input int nlines);
    for (int y = 0; y < nlines; y++) line(y);
    repeat (4) @(negedge clock_50);
  endtask

  task automatic wr(input logic [4:0] col, input logic [3:0] row, input logic [1:0] typ);
    bus.wr_en = 1'b1; bus.wr_col = col; bus.wr_row = row; bus.wr_type = typ;
    @(negedge clock_50);
    bus.wr_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock_50); #1;
  endtask

  task automatic wait_init(input bit probe_init_write);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 299) begin
        chk("init_done@299", bus.init_done, 0);
        chk("wr_ready@299", bus.wr_ready, 0);
      end
      if (i == 300) begin
        chk("init_done@300", bus.init_done, 1);
        chk("wr_ready@300", bus.wr_ready, 1);
      end
      if (probe_init_write && i == 250) begin
        bus.wr_en = 1'b1; bus.wr_col = 5'd3; bus.wr_row = 4'd2; bus.wr_type = 2'd2;
      end
      if (i == 251) bus.wr_en = 1'b0;
    end
    @(negedge clock_50);
  endtask

  initial begin
    idle();
    bus.wr_en = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_type = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock_50);
    chk("rst_rgb", {bus.R, bus.G, bus.B}, 0);
    chk("rst_vga_hs", bus.VGA_HS, 1);
    chk("rst_vga_vs", bus.VGA_VS, 1);
    chk("rst_vga_blank", bus.VGA_BLANK, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_init_done", bus.init_done, 0);
    reset_n = 1'b1;
    wait_init(1'b1);

    wr(5'd3, 4'd1, 2'd3);   // bomb at (3,1)
    wr(5'd2, 4'd1, 2'd2);   // brick at (2,1)
    wr(5'd25, 4'd0, 2'd3);  // out of range column; would alias to (5,1)
    wr(5'd0, 4'd15, 2'd3);  // out of range row
    @(negedge clock_50);

    clear_cp();
    add_cp(0, 0, 24'h404040);
    add_cp(79, 0, 24'h404040);
    add_cp(60, 60, 24'h20A020);
    add_cp(100, 100, 24'h808080);
    add_cp(100, 80, 24'h404040);
    add_cp(40, 45, GRID);
    add_cp(45, 45, 24'h20A020);
    add_cp(140, 60, 24'h000000);
    add_cp(125, 45, 24'h20A020);
    add_cp(120, 40, GRID);
    add_cp(85, 50, 24'h602010);
    add_cp(85, 55, 24'hB04020);
    add_cp(220, 60, 24'h20A020);
    add_cp(140, 85, 24'h20A020);
    frame(120);
    chk("frame1_hits", cp_hits, 14);
    clear_cp();

    // Sync and blank delay, RGB held black while blanked.
    idle();
    repeat (4) @(negedge clock_50);
    bus.HS = 1'b0; bus.VS = 1'b0;
    tick(); chk("hs_d1", bus.VGA_HS, 1);
    tick(); chk("hs_d2", bus.VGA_HS, 1);
    tick(); chk("hs_d3", bus.VGA_HS, 0);
    chk("vs_d3", bus.VGA_VS, 0);
    chk("blank_rgb", {bus.R, bus.G, bus.B}, 0);
    @(negedge clock_50);
    bus.HS = 1'b1; bus.VS = 1'b1; bus.blank = 1'b1;
    tick(); chk("blank_d1", bus.VGA_BLANK, 0);
    tick(); chk("blank_d2", bus.VGA_BLANK, 0);
    tick(); chk("blank_d3", bus.VGA_BLANK, 1);
    @(negedge clock_50);
    idle();
    repeat (4) @(negedge clock_50);

    // Reset partway through a line: outputs clear at once, map reloads.
    line(0);
    line(1);
    for (int x = 0; x < 50; x++) begin
      bus.blank = 1'b1; bus.SOL = (x == 0); bus.SOF = 1'b0; bus.EOL = 1'b0;
      @(negedge clock_50);
    end
    #5 reset_n = 1'b0;
    #1;
    chk("midrst_rgb", {bus.R, bus.G, bus.B}, 0);
    chk("midrst_vga_blank", bus.VGA_BLANK, 0);
    chk("midrst_init_done", bus.init_done, 0);
    chk("midrst_wr_ready", bus.wr_ready, 0);
    idle();
    @(negedge clock_50);
    reset_n = 1'b1;
    wait_init(1'b0);

    add_cp(0, 0, 24'h404040);
    add_cp(100, 20, 24'h808080);
    add_cp(140, 60, 24'h20A020);
    add_cp(85, 55, 24'h20A020);
    add_cp(60, 60, 24'h20A020);
    frame(70);
    chk("frame2_hits", cp_hits, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/arena_render.md
# arena_render

Pixel-colour stage placed directly downstream of the VGA timing generator (800×600 active, clock_50 pixel rate). It tracks the current 40×40-pixel arena cell from the timing strobes, looks up the cell type in an internal 20×15 map, and drives 8-bit RGB plus delayed HS/VS/blank to the DAC. Game logic updates the map through a single write port. A reset-time FSM loads the classic Bomberman border-and-pillar layout.

## Interface
- CELL_PX, 40: cell edge in pixels (square cells).
- MAP_W, 20: arena columns.
- MAP_H, 15: arena rows.
- LAT, 3: pipeline latency in clocks, input pixel to RGB.

- clock_50  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- HS, VS  in  1 each  timing syncs, active-low.
- blank  in  1  high in the active area.
- SOF, SOL, EOL  in  1 each  one-cycle strobes. SOL marks the first active pixel of a line. SOF coincides with SOL of line 0. EOL marks the last active pixel of a line.
- wr_en  in  1  map write request.
- wr_col  in  5  cell column.
- wr_row  in  4  cell row.
- wr_type  in  2  cell type: 0 empty, 1 wall, 2 brick, 3 bomb.
- wr_ready  out  1  high when writes are accepted.
- init_done  out  1  high once the map is initialised.
- R, G, B  out  8 each  pixel colour.
- VGA_HS, VGA_VS, VGA_BLANK  out  1 each  inputs delayed by LAT.

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT with address counter 0.
  - INIT writes one map entry per clock, addresses 0..299.
  - Entry value: wall if row∈{0,14}, col∈{0,19}, or (col even and row even). Otherwise empty.
  - After address 299 the FSM moves to RUN and stays there until the next reset.
- wr_ready = 0 in INIT, 1 in RUN.
- Map write in RUN: address = row·16 + row·4 + col.
  - Write with col ≥ 20 or row ≥ 15: ignored, no map change.
- Position counters px (0..39), col (0..19), py (0..39), row (0..14):
  - Current pixel position = (SOL ? 0 : px_reg, SOL ? 0 : col_reg).
  - Each cycle with blank = 1, px increments. On px = 39 it wraps to 0 and col increments.
  - SOF sets py = 0 and row = 0.
  - EOL without SOF: py increments. On py = 39 it wraps to 0 and row increments. row saturates at 14.
- Pipeline:
  - S1 registers position and syncs.
  - S2 synchronous map read. S2 also delays px, py and the syncs.
  - S3 colour lookup, registered to the outputs.
- Colour rules (24-bit RGB):
  - empty 0x20A020.
  - wall 0x808080, or 0x404040 when px or py ∈ {0, 39}.
  - brick 0xB04020, or mortar 0x602010 when py ∈ {0, 10, 20, 30}.
  - bomb 0x000000 when 8 ≤ px,py ≤ 31, otherwise empty colour.
- Output forced to 0x000000 when delayed blank = 0 or init_done = 0.

## Timing
- Reset values:
  - R, G, B = 0.
  - VGA_HS = VGA_VS = 1.
  - VGA_BLANK = 0.
  - wr_ready = 0, init_done = 0.
  - All counters and pipeline registers = 0.
- init_done rises 300 clocks after reset release. wr_ready rises in the same cycle.
- Latency: input pixel at cycle n appears on R/G/B at cycle n+3. VGA_HS, VGA_VS and VGA_BLANK follow the same 3-cycle delay.
- A write accepted at cycle n is visible to a map read at cycle n+1 or later.
- Same-cycle write and read of one address: the read returns the old value.
- Reset mid-frame: outputs and counters clear immediately and the map is re-initialised. Counters resynchronise at the next SOF.
- SOF and EOL in the same cycle: SOF wins (py = 0, row = 0).

## Configuration
- ARENA_GRID_EN defined:
  - Empty cells show grid colour 0x107010 when px = 0 or py = 0.
  - Bomb cells outside the 8..31 square also show the grid colour on those pixels.
- ARENA_GRID_EN undefined: no grid, plain empty colour as above.

## Test plan
- Reset release, then 300 clocks → init_done = 1 and wr_ready = 1 at clock 300. Both are 0 before that.
- Full frame after init → pixel (0,0) = 0x404040. Pixel (60,60), cell (1,1), = 0x20A020. Pixel (100,100), cell (2,2), = 0x808080.
- Write cell (3,1) = bomb → pixel (140,60) = 0x000000 and pixel (125,45) = empty colour. Each appears exactly 3 clocks after the matching input pixel.
- Write col = 25, row = 3 → no change in any map cell. Write during INIT → ignored.
- Sync delay: HS falling edge at cycle n → VGA_HS falls at n+3. blank = 0 → RGB = 0.
- ARENA_GRID_EN build, cell (1,1): px = 0 → 0x107010, px = 5 → 0x20A020. Default build, px = 0 → 0x20A020.
